// File: rtl/fp_div_sched_pkg.sv
// Shared types for the FP divide/sqrt scheduler: FSM state encoding and request queue entry.
package fp_div_sched_pkg;

   localparam int MAX_W   = 64;
   localparam int MAX_PTR = 8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_RES,
      WAIT_DRAIN
   } sched_state_t;

   // Fields are sized for the widest configuration; unused upper bits stay zero and are trimmed.
   typedef struct packed {
      logic [MAX_W-1:0]   a;
      logic [MAX_W-1:0]   b;
      logic               sqrt;
      logic [MAX_PTR-1:0] rob_ptr;
      logic [MAX_PTR-1:0] dst_ptr;
   } q_entry_t;

endpackage

// File: rtl/fp_div_req_q.sv
// In-order request FIFO of depth 2**LG_Q; the extra pointer bit separates full from empty.
module fp_div_req_q
   import fp_div_sched_pkg::*;
#(
   parameter int LG_Q = 2
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     i_flush,
   input  logic     i_push,
   input  q_entry_t i_entry,
   input  logic     i_pop,
   output q_entry_t o_head,
   output logic     o_full,
   output logic     o_empty
);

   localparam int DEPTH = 2 ** LG_Q;

   logic [LG_Q:0] r_wr_ptr;
   logic [LG_Q:0] r_rd_ptr;
   q_entry_t      r_mem [DEPTH];
   logic          w_do_push;
   logic          w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[LG_Q] != r_rd_ptr[LG_Q]) &&
                      (r_wr_ptr[LG_Q-1:0] == r_rd_ptr[LG_Q-1:0]);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_head    = r_mem[r_rd_ptr[LG_Q-1:0]];

   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[LG_Q-1:0]] <= i_entry;
   end

endmodule

// File: rtl/fp_div_sched.sv
// Issue scheduler for a single non-pipelined FP divide/sqrt unit with a 1-entry result buffer.
// Optional macro FP_DIV_SCHED_BYPASS_EN: launch a request straight to an idle divider when the queue is empty.
module fp_div_sched
   import fp_div_sched_pkg::*;
#(
   parameter int W            = 32,
   parameter int LG_ROB_WIDTH = 1,
   parameter int LG_PRF_WIDTH = 1,
   parameter int LG_Q         = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic [W-1:0]            i_req_a,
   input  logic [W-1:0]            i_req_b,
   input  logic                    i_req_sqrt,
   input  logic [LG_ROB_WIDTH-1:0] i_req_rob_ptr,
   input  logic [LG_PRF_WIDTH-1:0] i_req_dst_ptr,
   input  logic                    i_flush,
   output logic                    o_div_start,
   output logic [W-1:0]            o_div_a,
   output logic [W-1:0]            o_div_b,
   output logic                    o_div_is_sqrt,
   output logic [LG_ROB_WIDTH-1:0] o_div_rob_ptr,
   output logic [LG_PRF_WIDTH-1:0] o_div_dst_ptr,
   input  logic                    i_div_active,
   input  logic                    i_div_valid,
   input  logic [W-1:0]            i_div_y,
   input  logic [LG_ROB_WIDTH-1:0] i_div_rob_ptr_out,
   input  logic [LG_PRF_WIDTH-1:0] i_div_dst_ptr_out,
   output logic                    o_res_valid,
   input  logic                    i_res_ready,
   output logic [W-1:0]            o_res_y,
   output logic [LG_ROB_WIDTH-1:0] o_res_rob_ptr,
   output logic [LG_PRF_WIDTH-1:0] o_res_dst_ptr,
   output logic                    o_busy
);

   sched_state_t            r_state;
   logic                    r_kill;
   logic                    r_res_valid;
   logic [W-1:0]            r_res_y;
   logic [LG_ROB_WIDTH-1:0] r_res_rob_ptr;
   logic [LG_PRF_WIDTH-1:0] r_res_dst_ptr;

   q_entry_t                w_enq;
   q_entry_t                w_head;
   logic [$bits(q_entry_t)-1:0] w_unused_head;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_push;
   logic                    w_can_start;
   logic                    w_q_start;
   logic                    w_bypass;

   fp_div_req_q #(.LG_Q(LG_Q)) u_req_q (
      .clk     (clk),
      .reset   (reset),
      .i_flush (i_flush),
      .i_push  (w_push),
      .i_entry (w_enq),
      .i_pop   (w_q_start),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_unused_head = w_head;

   // Launch is combinational so a queued op starts the cycle after it was accepted.
   always_comb begin
      w_enq                              = '0;
      w_enq.a[W-1:0]                     = i_req_a;
      w_enq.b[W-1:0]                     = i_req_b;
      w_enq.sqrt                         = i_req_sqrt;
      w_enq.rob_ptr[LG_ROB_WIDTH-1:0]    = i_req_rob_ptr;
      w_enq.dst_ptr[LG_PRF_WIDTH-1:0]    = i_req_dst_ptr;

      w_can_start = (r_state == IDLE) && !r_res_valid && !i_div_active && !i_flush;
      w_q_start   = w_can_start && !w_empty;
`ifdef FP_DIV_SCHED_BYPASS_EN
      w_bypass    = w_can_start && w_empty && i_req_valid;
`else
      w_bypass    = 1'b0;
`endif
      o_req_ready = !w_full && !i_flush;
      w_push      = i_req_valid && o_req_ready && !w_bypass;
      o_div_start = w_q_start || w_bypass;

      o_div_a       = '0;
      o_div_b       = '0;
      o_div_is_sqrt = 1'b0;
      o_div_rob_ptr = '0;
      o_div_dst_ptr = '0;
      if (w_bypass) begin
         o_div_a       = i_req_a;
         o_div_b       = i_req_b;
         o_div_is_sqrt = i_req_sqrt;
         o_div_rob_ptr = i_req_rob_ptr;
         o_div_dst_ptr = i_req_dst_ptr;
      end else if (w_q_start) begin
         o_div_a       = w_head.a[W-1:0];
         o_div_b       = w_head.b[W-1:0];
         o_div_is_sqrt = w_head.sqrt;
         o_div_rob_ptr = w_head.rob_ptr[LG_ROB_WIDTH-1:0];
         o_div_dst_ptr = w_head.dst_ptr[LG_PRF_WIDTH-1:0];
      end
   end

   // A killed op still walks WAIT_RES -> WAIT_DRAIN -> IDLE because the divider cannot be aborted.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_kill        <= 1'b0;
         r_res_valid   <= 1'b0;
         r_res_y       <= '0;
         r_res_rob_ptr <= '0;
         r_res_dst_ptr <= '0;
      end else begin
         if (r_res_valid && i_res_ready) r_res_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (o_div_start) r_state <= WAIT_RES;
            end
            WAIT_RES: begin
               if (i_flush) r_kill <= 1'b1;
               if (i_div_valid) begin
                  r_state <= WAIT_DRAIN;
                  r_kill  <= 1'b0;
                  if (!r_kill && !i_flush) begin
                     r_res_valid   <= 1'b1;
                     r_res_y       <= i_div_y;
                     r_res_rob_ptr <= i_div_rob_ptr_out;
                     r_res_dst_ptr <= i_div_dst_ptr_out;
                  end
               end
            end
            WAIT_DRAIN: begin
               if (!i_div_active) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
         if (i_flush) r_res_valid <= 1'b0;
      end
   end

   assign o_res_valid   = r_res_valid;
   assign o_res_y       = r_res_y;
   assign o_res_rob_ptr = r_res_rob_ptr;
   assign o_res_dst_ptr = r_res_dst_ptr;
   assign o_busy        = !w_empty || (r_state != IDLE) || r_res_valid || o_div_start;

endmodule

// File: tb/tb_fp_div_sched.sv
// Self-checking bench for fp_div_sched with a behavioural fixed-latency divider model.
module tb_fp_div_sched;

   localparam int W        = 32;
   localparam int LR       = 2;
   localparam int LP       = 2;
   localparam int LQ       = 2;
   localparam int LAT      = 8;
   localparam int VALID_AT = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          reqValid;
   logic          reqReady;
   logic [W-1:0]  reqA;
   logic [W-1:0]  reqB;
   logic          reqSqrt;
   logic [LR-1:0] reqRob;
   logic [LP-1:0] reqDst;
   logic          flush;
   logic          divStart;
   logic [W-1:0]  divA;
   logic [W-1:0]  divB;
   logic          divIsSqrt;
   logic [LR-1:0] divRob;
   logic [LP-1:0] divDst;
   logic          divActive = 1'b0;
   logic          divValid = 1'b0;
   logic [W-1:0]  divY = '0;
   logic [LR-1:0] divRobOut = '0;
   logic [LP-1:0] divDstOut = '0;
   logic          resValid;
   logic          resReady;
   logic [W-1:0]  resY;
   logic [LR-1:0] resRob;
   logic [LP-1:0] resDst;
   logic          busy;

   int errors = 0;
   int checks = 0;
   int divCnt = 0;
   int cycle = 0;
   int startCount = 0;
   int violations = 0;
   int lastDivValidCyc = 0;
   int lastResRiseCyc = 0;
   logic prevResValid = 1'b0;
   logic [W-1:0]  resYQ [$];
   logic [LR-1:0] resRobQ [$];
   logic [LP-1:0] resDstQ [$];

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sqrt;
      logic [1:0]  rob;
      logic [1:0]  dst;
      logic [31:0] expY;
   } vec_t;
   vec_t vecs [6];

   always #5 clk = ~clk;

   fp_div_sched #(.W(W), .LG_ROB_WIDTH(LR), .LG_PRF_WIDTH(LP), .LG_Q(LQ)) dut (
      .clk               (clk),
      .reset             (reset),
      .i_req_valid       (reqValid),
      .o_req_ready       (reqReady),
      .i_req_a           (reqA),
      .i_req_b           (reqB),
      .i_req_sqrt        (reqSqrt),
      .i_req_rob_ptr     (reqRob),
      .i_req_dst_ptr     (reqDst),
      .i_flush           (flush),
      .o_div_start       (divStart),
      .o_div_a           (divA),
      .o_div_b           (divB),
      .o_div_is_sqrt     (divIsSqrt),
      .o_div_rob_ptr     (divRob),
      .o_div_dst_ptr     (divDst),
      .i_div_active      (divActive),
      .i_div_valid       (divValid),
      .i_div_y           (divY),
      .i_div_rob_ptr_out (divRobOut),
      .i_div_dst_ptr_out (divDstOut),
      .o_res_valid       (resValid),
      .i_res_ready       (resReady),
      .o_res_y           (resY),
      .o_res_rob_ptr     (resRob),
      .o_res_dst_ptr     (resDst),
      .o_busy            (busy)
   );

   // Quotient / root lookup for the operands this bench uses.
   function automatic logic [W-1:0] divModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      logic [63:0] key;
      key = {a, b};
      if (s) begin
         case (a)
            32'h40800000: return 32'h40000000;
            32'h41100000: return 32'h40400000;
            default:      return 32'hDEADBEEF;
         endcase
      end
      case (key)
         64'h3F800000_40000000: return 32'h3F000000;
         64'h40C00000_40400000: return 32'h40000000;
         64'h41200000_40A00000: return 32'h40000000;
         64'h42C80000_41200000: return 32'h41200000;
         default:               return 32'hDEADBEEF;
      endcase
   endfunction

   // Divider: busy LAT cycles after start, result pulse in cycle VALID_AT, shares reset.
   always @(posedge clk) begin
      if (reset) begin
         divCnt    <= 0;
         divActive <= 1'b0;
         divValid  <= 1'b0;
      end else begin
         divValid <= 1'b0;
         if (divStart) begin
            divCnt    <= 1;
            divActive <= 1'b1;
            divY      <= divModel(divA, divB, divIsSqrt);
            divRobOut <= divRob;
            divDstOut <= divDst;
         end else if (divActive) begin
            divCnt <= divCnt + 1;
            if (divCnt == VALID_AT - 1) divValid <= 1'b1;
            if (divCnt == LAT - 1) divActive <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      cycle <= cycle + 1;
      prevResValid <= resValid;
      if (!reset) begin
         if (divStart) begin
            startCount <= startCount + 1;
            if (divActive) violations <= violations + 1;
         end
         if (divValid) lastDivValidCyc <= cycle;
         if (resValid && !prevResValid) lastResRiseCyc <= cycle;
         if (resValid && resReady) begin
            resYQ.push_back(resY);
            resRobQ.push_back(resRob);
            resDstQ.push_back(resDst);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: timed out", name);
   endtask

   task automatic clearResults();
      resYQ.delete();
      resRobQ.delete();
      resDstQ.delete();
   endtask

   // Called just after a rising edge; returns just after the edge that transferred the request.
   task automatic applyStimulus(input vec_t v);
      int n;
      reqValid = 1'b1;
      reqA     = v.a;
      reqB     = v.b;
      reqSqrt  = v.sqrt;
      reqRob   = v.rob;
      reqDst   = v.dst;
      n = 0;
      @(negedge clk);
      while (!reqReady && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!reqReady) timeoutFail("reqAccept");
      @(posedge clk);
      #1;
      reqValid = 1'b0;
   endtask

   task automatic waitResults(input int num);
      int n;
      n = 0;
      while (resYQ.size() < num && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (resYQ.size() < num) timeoutFail("waitResults");
      @(posedge clk);
      #1;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      @(negedge clk);
      while ((busy || divActive) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (busy || divActive) timeoutFail("waitIdle");
      @(posedge clk);
      #1;
   endtask

   task automatic checkResult(input string name, input int idx, input vec_t v);
      checkOutput({name, "_y"}, resYQ[idx], v.expY);
      checkOutput({name, "_rob"}, resRobQ[idx], v.rob);
      checkOutput({name, "_dst"}, resDstQ[idx], v.dst);
   endtask

   initial begin
      int s0;
      int unstable;
      int readyHigh;
      logic [W-1:0] snapY;
      logic [LR-1:0] snapRob;
      logic [LP-1:0] snapDst;

      vecs[0] = '{32'h3F800000, 32'h40000000, 1'b0, 2'd1, 2'd3, 32'h3F000000};
      vecs[1] = '{32'h40C00000, 32'h40400000, 1'b0, 2'd0, 2'd1, 32'h40000000};
      vecs[2] = '{32'h41200000, 32'h40A00000, 1'b0, 2'd2, 2'd2, 32'h40000000};
      vecs[3] = '{32'h40800000, 32'h00000000, 1'b1, 2'd3, 2'd0, 32'h40000000};
      vecs[4] = '{32'h41100000, 32'h00000000, 1'b1, 2'd1, 2'd1, 32'h40400000};
      vecs[5] = '{32'h42C80000, 32'h41200000, 1'b0, 2'd2, 2'd3, 32'h41200000};

      reset = 1'b1; reqValid = 1'b0; reqA = '0; reqB = '0; reqSqrt = 1'b0;
      reqRob = '0; reqDst = '0; flush = 1'b0; resReady = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("rstDivStart", divStart, 1'b0);
      checkOutput("rstResValid", resValid, 1'b0);
      checkOutput("rstBusy", busy, 1'b0);
      checkOutput("rstReqReady", reqReady, 1'b1);
      checkOutput("rstResY", resY, '0);
      @(posedge clk);
      #1;

      $display("[TB] single operations");
      for (int i = 0; i < 6; i++) begin
         clearResults();
         s0 = startCount;
         applyStimulus(vecs[i]);
         waitResults(1);
         waitIdle();
         checkResult($sformatf("single%0d", i), 0, vecs[i]);
         if (i == 0) begin
            checkOutput("singleStarts", startCount - s0, 1);
            checkOutput("resLatency", lastResRiseCyc - lastDivValidCyc, 1);
         end
      end

      $display("[TB] back-to-back");
      clearResults();
      s0 = startCount;
      applyStimulus(vecs[1]);
      applyStimulus(vecs[2]);
      waitResults(2);
      waitIdle();
      checkResult("b2bFirst", 0, vecs[1]);
      checkResult("b2bSecond", 1, vecs[2]);
      checkOutput("b2bStarts", startCount - s0, 2);

      $display("[TB] queue fill and backpressure");
      clearResults();
      resReady = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput("queueFull", reqReady, 1'b0);
      begin
         int n;
         n = 0;
         while (!resValid && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (!resValid) timeoutFail("bufferFill");
      end
      @(posedge clk);
      #1;
      reqValid = 1'b1;
      reqA = vecs[5].a; reqB = vecs[5].b; reqSqrt = vecs[5].sqrt;
      reqRob = vecs[5].rob; reqDst = vecs[5].dst;
      snapY = resY; snapRob = resRob; snapDst = resDst;
      s0 = startCount;
      unstable = 0;
      readyHigh = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (resValid !== 1'b1 || resY !== snapY || resRob !== snapRob || resDst !== snapDst) unstable++;
         if (reqReady) readyHigh++;
      end
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      checkOutput("holdStable", unstable, 0);
      checkOutput("holdFullReady", readyHigh, 0);
      checkOutput("holdStarts", startCount - s0, 0);
      checkOutput("holdPayload", {snapY, snapRob, snapDst}, {vecs[0].expY, vecs[0].rob, vecs[0].dst});
      resReady = 1'b1;
      applyStimulus(vecs[5]);
      waitResults(6);
      waitIdle();
      checkOutput("fillCount", resYQ.size(), 6);
      for (int i = 0; i < 6; i++)
         checkOutput($sformatf("fillOrder%0d", i), {resYQ[i], resRobQ[i], resDstQ[i]},
                     {vecs[i].expY, vecs[i].rob, vecs[i].dst});

      $display("[TB] flush while waiting for result");
      clearResults();
      s0 = startCount;
      applyStimulus(vecs[0]);
      applyStimulus(vecs[1]);
      applyStimulus(vecs[2]);
      flush = 1'b1;
      @(negedge clk);
      checkOutput("flushReqReady", reqReady, 1'b0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      waitIdle();
      checkOutput("flushNoResult", resYQ.size(), 0);
      checkOutput("flushBusy", busy, 1'b0);
      checkOutput("flushStarts", startCount - s0, 1);
      applyStimulus(vecs[5]);
      waitResults(1);
      waitIdle();
      checkResult("afterFlush", 0, vecs[5]);

      $display("[TB] flush coincident with divider result");
      clearResults();
      applyStimulus(vecs[3]);
      begin
         int n;
         n = 0;
         @(negedge clk);
         while (!divValid && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (!divValid) timeoutFail("divValidWait");
      end
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      checkOutput("flushOnValidRes", resValid, 1'b0);
      @(posedge clk);
      #1;
      waitIdle();
      checkOutput("flushOnValidNone", resYQ.size(), 0);
      applyStimulus(vecs[4]);
      waitResults(1);
      waitIdle();
      checkResult("afterFlushValid", 0, vecs[4]);

      $display("[TB] reset mid-divide");
      clearResults();
      applyStimulus(vecs[0]);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("midRstResValid", resValid, 1'b0);
      checkOutput("midRstBusy", busy, 1'b0);
      checkOutput("midRstReqReady", reqReady, 1'b1);
      repeat (15) @(negedge clk);
      checkOutput("midRstNoResult", resYQ.size(), 0);

      checkOutput("startWhileActive", violations, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
